// File: rtl/req_queue_bank.sv
// req_queue_bank: per-requester FIFO bank in front of a round-robin arbiter.
//
// Each requester owns a DEPTH-entry circular queue. Queue occupancy drives
// req_vector toward the arbiter. A grant pops the head of the granted queue
// into a registered output beat (out_valid/out_data/out_src). A grant that
// finds an empty queue, or that names an index with no queue behind it,
// sets the sticky stale_grant flag.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   push_valid/push_data per-requester write strobe and payload (flat bus)
//   push_ready           queue i not full
//   req_vector           queue i non-empty
//   grant_idx/valid      arbiter grant
//   out_valid/data/src   registered output beat, one cycle per pop
//   stale_grant          sticky: a grant hit an empty queue

// One queue lane: circular buffer with write/read pointers and a count.
module req_queue_lane #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  input  logic              grant_hit,
  output logic              push_ready,
  output logic              not_empty,
  output logic              pop_fire,
  output logic [DATA_W-1:0] head_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         push_fire;

  // Flow control looks at the registered count only, so a full queue
  // refuses a push even in the cycle it is being popped.
  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign not_empty  = (count_q != '0);
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = grant_hit & not_empty;
  assign head_data  = mem_q[rptr_q];

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_fire) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop_fire) rptr_d = rptr_q + PTR_W'(1);
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule

module req_queue_bank #(
  parameter int WIDTH  = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           push_valid,
  input  logic [WIDTH*DATA_W-1:0]    push_data,
  output logic [WIDTH-1:0]           push_ready,
  output logic [WIDTH-1:0]           req_vector,
  input  logic [$clog2(WIDTH)-1:0]   grant_idx,
  input  logic                       grant_valid,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(WIDTH)-1:0]   out_src,
  output logic                       stale_grant
);
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0]             grant_hit, pop_vec;
  logic [WIDTH-1:0][DATA_W-1:0] head;
  logic [DATA_W-1:0]            pop_data;
  logic                         pop_any;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_src_q, out_src_d;
  logic              stale_grant_q, stale_grant_d;

  // A grant index with no queue behind it matches no lane, so it falls
  // through to the stale path like a grant to an empty queue.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign grant_hit[i] = grant_valid && (grant_idx == IDX_W'(i));
    req_queue_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .push_valid (push_valid[i]),
      .push_data  (push_data[i*DATA_W +: DATA_W]),
      .grant_hit  (grant_hit[i]),
      .push_ready (push_ready[i]),
      .not_empty  (req_vector[i]),
      .pop_fire   (pop_vec[i]),
      .head_data  (head[i])
    );
  end

  assign pop_any = |pop_vec;

  // pop_vec is at most one-hot, so an AND-OR mux selects the popped head.
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < WIDTH; i++)
      if (pop_vec[i]) pop_data = pop_data | head[i];
  end

  always_comb begin
    out_valid_d   = pop_any;
    out_data_d    = out_data_q;
    out_src_d     = out_src_q;
    stale_grant_d = stale_grant_q | (grant_valid & ~pop_any);
    if (pop_any) begin
      out_data_d = pop_data;
      out_src_d  = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_src_q     <= '0;
      stale_grant_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_src_q     <= out_src_d;
      stale_grant_q <= stale_grant_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_src     = out_src_q;
  assign stale_grant = stale_grant_q;
endmodule
